// File: rtl/apb_pkg.sv
// Shared definitions for the APB command path: state encodings and helpers that
// locate the {pwrite, addr, wdata} fields inside a packed command word.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      APB_IDLE   = 2'd0,
      APB_SETUP  = 2'd1,
      APB_ACCESS = 2'd2
   } apb_phase_t;

   // Command word is {pwrite, addr, wdata}, MSB first.
   function automatic int cmd_pwrite_bit(input int data_wd, input int addr_wd);
      return data_wd + addr_wd;
   endfunction

   function automatic int cmd_addr_lsb(input int data_wd);
      return data_wd;
   endfunction

   function automatic int cmd_data_lsb();
      return 0;
   endfunction

   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ; returns one-hot grant, its index and an any flag.
module apb_rr_pick
   import apb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   int cand;

   // Scan from the farthest offset back to offset 0 so the nearest hit wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = (int'(ptr) + k) % NUM_REQ;
         if (req[cand]) begin
            any         = 1'b1;
            idx         = IDX_W'(cand);
            grant       = '0;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_cmd_arbiter.sv
// Round-robin arbiter letting NUM_REQ requesters share one apb_master; tracks a
// single transfer from handshake to APB completion and pulses the owner's rsp_vld.
module apb_cmd_arbiter
   import apb_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   parameter  int DATA_WD = 8,
   parameter  int ADDR_WD = 8,
   localparam int CMD_WD  = DATA_WD + ADDR_WD + 1,
   localparam int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ*CMD_WD-1:0] req_cmd,
   input  logic [NUM_REQ-1:0]        req_vld,
   output logic [NUM_REQ-1:0]        req_rdy,
   output logic [NUM_REQ-1:0]        rsp_vld,
   output logic                      rsp_write,
   output logic [DATA_WD-1:0]        rsp_data,
   output logic [CMD_WD-1:0]         m_cmd_in,
   output logic                      m_cmd_vld,
   input  logic                      m_cmd_rdy,
   input  logic                      m_psel,
   input  logic                      m_penable,
   input  logic                      m_pready,
   input  logic [DATA_WD-1:0]        m_prdata,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      busy
);

   localparam int PW_BIT = cmd_pwrite_bit(DATA_WD, ADDR_WD);

   arb_state_t          state_reg;
   arb_state_t          state_next;
   logic [CMD_WD-1:0]   hold_reg;
   logic [IDX_W-1:0]    owner_reg;
   logic [IDX_W-1:0]    grant_reg;
   logic [IDX_W-1:0]    rr_ptr_reg;
   logic [IDX_W-1:0]    rr_ptr_next;
   logic [NUM_REQ-1:0]  rsp_vld_reg;
   logic                rsp_write_reg;
   logic [DATA_WD-1:0]  rsp_data_reg;

   logic [NUM_REQ-1:0]  pick_grant;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;
   logic [CMD_WD-1:0]   sel_cmd;
   logic [NUM_REQ-1:0]  owner_onehot;
   logic                handshake;
   logic                completion;

   apb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (req_vld),
      .ptr   (rr_ptr_reg),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign handshake  = (state_reg == ST_IDLE) && pick_any;
   assign completion = (state_reg == ST_WAIT) && m_psel && m_penable && m_pready;

   always_comb begin
      sel_cmd = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_grant[i]) begin
            sel_cmd = req_cmd[i*CMD_WD +: CMD_WD];
         end
      end
   end

   always_comb begin
      owner_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         owner_onehot[i] = (owner_reg == IDX_W'(i));
      end
   end

   assign rr_ptr_next = (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (pick_any)   state_next = ST_ISSUE;
         ST_ISSUE: if (m_cmd_rdy)  state_next = ST_WAIT;
         ST_WAIT:  if (completion) state_next = ST_IDLE;
         default:                  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_reg      <= '0;
         owner_reg     <= '0;
         grant_reg     <= '0;
         rr_ptr_reg    <= '0;
         rsp_vld_reg   <= '0;
         rsp_write_reg <= 1'b0;
         rsp_data_reg  <= '0;
      end else begin
         rsp_vld_reg <= '0;
         if (handshake) begin
            hold_reg  <= sel_cmd;
            owner_reg <= pick_idx;
            grant_reg <= pick_idx;
         end
         // Pointer moves only on completion, so the rsp_vld cycle arbitrates fairly.
         if (completion) begin
            rsp_vld_reg   <= owner_onehot;
            rsp_write_reg <= hold_reg[PW_BIT];
            rsp_data_reg  <= hold_reg[PW_BIT] ? '0 : m_prdata;
            rr_ptr_reg    <= rr_ptr_next;
         end
      end
   end

   // Gated by rst_n so ready is low while reset is held even with requests pending.
   assign req_rdy   = ((state_reg == ST_IDLE) && rst_n) ? pick_grant : '0;
   assign m_cmd_vld = (state_reg == ST_ISSUE);
   assign m_cmd_in  = hold_reg;
   assign busy      = (state_reg != ST_IDLE);
   assign grant_id  = grant_reg;
   assign rsp_vld   = rsp_vld_reg;
   assign rsp_write = rsp_write_reg;
   assign rsp_data  = rsp_data_reg;

endmodule
